// File: rtl/i2c_curr_poller.sv
// ---------------------------------------------------------------------------
// i2c_curr_poller
//   Autonomous sequencer sitting upstream of i2cMaster. On every poll tick it
//   requests the bus mutex, runs a pointer-write + 2-byte-read transaction
//   against a current-sense device, publishes the 16-bit reading and tracks
//   consecutive over-limit samples for a sticky over-current interrupt.
//   NACK/line errors are retried up to RETRY_MAX times before a sticky fault.
//
// Ports
//   clk, rstn            system clock, async active-low reset
//   enable               polling enable (level)
//   limit                unsigned over-current threshold, used in EVAL only
//   ocClr, faultClr      one-cycle clear pulses
//   mWrBuf/mWrLen/
//   mRdLen/mAddr         constant transaction descriptor to i2cMaster
//   mStart               one-cycle start pulse to i2cMaster
//   mBusy, mDone,
//   mErrLine, mErrNack,
//   mRdBuf               i2cMaster status / read data
//   mMutexSta/mMutexGet  bus mutex ownership / request pulse
//   sample, sampleValid  last good reading and its update strobe
//   ocIrq, fault         sticky status flags
//   overrun              pulse when a tick lands on a poll still in progress
// ---------------------------------------------------------------------------
module i2c_curr_poller #(
  parameter int         SYS_CLK_FREQ   = 10_000_000,
  parameter int         POLL_PERIOD_US = 1000,
  parameter logic [6:0] DEV_ADDR       = 7'h40,
  parameter logic [7:0] REG_PTR        = 8'h01,
  parameter int         CONSEC_N       = 2,
  parameter int         RETRY_MAX      = 3,
  parameter int         MUTEX_TMO_CYC  = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [15:0] limit,
  input  logic        ocClr,
  input  logic        faultClr,
  output logic [31:0] mWrBuf,
  output logic [2:0]  mWrLen,
  output logic [2:0]  mRdLen,
  output logic [6:0]  mAddr,
  output logic        mStart,
  input  logic        mBusy,
  input  logic        mDone,
  input  logic        mErrLine,
  input  logic        mErrNack,
  input  logic [31:0] mRdBuf,
  input  logic        mMutexSta,
  output logic        mMutexGet,
  output logic [15:0] sample,
  output logic        sampleValid,
  output logic        ocIrq,
  output logic        fault,
  output logic        overrun
);

  localparam int         POLL_CYC    = SYS_CLK_FREQ / 1_000_000 * POLL_PERIOD_US;
  localparam logic [31:0] TICK_RELOAD = 32'(POLL_CYC - 1);
  localparam logic [31:0] MTX_LAST    = 32'(MUTEX_TMO_CYC - 1);
  localparam logic [3:0]  CONSEC_MAX  = 4'(CONSEC_N);
  localparam logic [7:0]  RETRY_LIM   = 8'(RETRY_MAX);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ       = 3'd1;
  localparam logic [2:0] S_WAIT_MTX  = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_EVAL      = 3'd5;
  localparam logic [2:0] S_ERR       = 3'd6;
  localparam logic [2:0] S_FAULT     = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic [31:0] mtx_cnt_q, mtx_cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [3:0]  consec_q, consec_d;
  logic [15:0] rd_q, rd_d;
  logic [15:0] sample_q, sample_d;
  logic        sample_valid_q, sample_valid_d;
  logic        oc_irq_q, oc_irq_d;
  logic        fault_q, fault_d;
  logic        overrun_q, overrun_d;

  logic        tick;
  logic        over_lim;
  logic [3:0]  consec_nxt;
  logic        oc_set;

  // Upper read bytes are not part of the 2-byte register read.
  logic unused_rd_hi;
  assign unused_rd_hi = ^mRdBuf[31:16];

  assign tick = enable && (tick_cnt_q == 32'd0);

  // Over-limit run length, saturating so a steady over-current keeps
  // re-asserting the set condition without wrapping.
  assign over_lim   = (rd_q >= limit);
  assign consec_nxt = !over_lim ? 4'd0 :
                      (consec_q >= CONSEC_MAX) ? CONSEC_MAX : consec_q + 4'd1;
  assign oc_set     = (consec_nxt == CONSEC_MAX);

  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    mtx_cnt_d      = mtx_cnt_q;
    retry_d        = retry_q;
    consec_d       = consec_q;
    rd_d           = rd_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    oc_irq_d       = oc_irq_q;
    fault_d        = fault_q;
    // Ticks are never queued; a tick outside IDLE is only reported.
    overrun_d      = tick && (state_q != S_IDLE);

    if (!enable)                    tick_cnt_d = TICK_RELOAD;
    else if (tick_cnt_q == 32'd0)   tick_cnt_d = TICK_RELOAD;
    else                            tick_cnt_d = tick_cnt_q - 32'd1;

    if (ocClr) begin
      oc_irq_d = 1'b0;
      consec_d = 4'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (tick && !fault_q) state_d = S_REQ;
      end
      S_REQ: begin
        mtx_cnt_d = 32'd0;
        state_d   = enable ? S_WAIT_MTX : S_IDLE;
      end
      S_WAIT_MTX: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (mMutexSta && !mBusy) begin
          state_d = S_START;
        end else if (mtx_cnt_q == MTX_LAST) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          mtx_cnt_d = mtx_cnt_q + 32'd1;
        end
      end
      // mStart fires this cycle, so the transaction is in flight regardless
      // of enable and must be allowed to complete.
      S_START: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (mDone) begin
          // Capture with mDone so EVAL does not depend on mRdBuf holding.
          rd_d    = {mRdBuf[7:0], mRdBuf[15:8]};
          state_d = (mErrLine || mErrNack) ? S_ERR : S_EVAL;
        end
      end
      S_EVAL: begin
        sample_d       = rd_q;
        sample_valid_d = 1'b1;
        retry_d        = 8'd0;
        consec_d       = ocClr ? 4'd0 : consec_nxt;
        // Set beats a coincident clear.
        if (oc_set) oc_irq_d = 1'b1;
        state_d        = S_IDLE;
      end
      S_ERR: begin
        if (!enable) begin
          retry_d = 8'd0;
          state_d = S_IDLE;
        end else if (retry_q < RETRY_LIM) begin
          // Mutex is still held; retry straight from START.
          retry_d = retry_q + 8'd1;
          state_d = S_START;
        end else begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        if (faultClr) begin
          fault_d = 1'b0;
          retry_d = 8'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      tick_cnt_q     <= TICK_RELOAD;
      mtx_cnt_q      <= 32'd0;
      retry_q        <= 8'd0;
      consec_q       <= 4'd0;
      rd_q           <= 16'd0;
      sample_q       <= 16'd0;
      sample_valid_q <= 1'b0;
      oc_irq_q       <= 1'b0;
      fault_q        <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      mtx_cnt_q      <= mtx_cnt_d;
      retry_q        <= retry_d;
      consec_q       <= consec_d;
      rd_q           <= rd_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      oc_irq_q       <= oc_irq_d;
      fault_q        <= fault_d;
      overrun_q      <= overrun_d;
    end
  end

  // Request/start pulses decode straight from state so reset kills them
  // asynchronously.
  assign mMutexGet   = (state_q == S_REQ);
  assign mStart      = (state_q == S_START);
  assign mWrBuf      = {24'h0, REG_PTR};
  assign mWrLen      = 3'd1;
  assign mRdLen      = 3'd2;
  assign mAddr       = DEV_ADDR;
  assign sample      = sample_q;
  assign sampleValid = sample_valid_q;
  assign ocIrq       = oc_irq_q;
  assign fault       = fault_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_i2c_curr_poller.sv
// ---------------------------------------------------------------------------
// tb_i2c_curr_poller
//   Directed + randomized bench. The bench plays i2cMaster and the mutex;
//   the expected ocIrq comes from a history queue of over-limit results
//   (raise when the last CONSEC_N results since a clear are all over-limit).
// ---------------------------------------------------------------------------
module tb_i2c_curr_poller;
  localparam int POLL_CYC = 1000;
  localparam int TMO      = 4096;
  localparam int CN       = 2;
  localparam int RM       = 3;

  logic        clk = 1'b0, rstn = 1'b0, enable = 1'b0;
  logic        ocClr = 1'b0, faultClr = 1'b0;
  logic [15:0] limit = 16'hFFFF;
  logic        mBusy = 1'b0, mDone = 1'b0, mErrLine = 1'b0, mErrNack = 1'b0;
  logic        mMutexSta = 1'b1;
  logic [31:0] mRdBuf = 32'h0;
  logic [31:0] mWrBuf;
  logic [2:0]  mWrLen, mRdLen;
  logic [6:0]  mAddr;
  logic        mStart, mMutexGet, sampleValid, ocIrq, fault, overrun;
  logic [15:0] sample;

  i2c_curr_poller #(
    .SYS_CLK_FREQ(10_000_000), .POLL_PERIOD_US(100), .DEV_ADDR(7'h40),
    .REG_PTR(8'h01), .CONSEC_N(CN), .RETRY_MAX(RM), .MUTEX_TMO_CYC(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .limit(limit), .ocClr(ocClr),
    .faultClr(faultClr), .mWrBuf(mWrBuf), .mWrLen(mWrLen), .mRdLen(mRdLen),
    .mAddr(mAddr), .mStart(mStart), .mBusy(mBusy), .mDone(mDone),
    .mErrLine(mErrLine), .mErrNack(mErrNack), .mRdBuf(mRdBuf),
    .mMutexSta(mMutexSta), .mMutexGet(mMutexGet), .sample(sample),
    .sampleValid(sampleValid), .ocIrq(ocIrq), .fault(fault), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0, n_start = 0, n_get = 0, n_sv = 0, n_ovr = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mStart)      n_start <= n_start + 1;
    if (mMutexGet)   n_get   <= n_get + 1;
    if (sampleValid) n_sv    <= n_sv + 1;
    if (overrun)     n_ovr   <= n_ovr + 1;
  end

  int passed = 0, total = 0;
  int last_get_cyc = 0;
  bit oc_m = 1'b0;
  bit hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // which: 0 = mMutexGet, 1 = mStart, 2 = overrun
  task automatic wait_sig(input int which, input int bound, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      case (which)
        0: seen = mMutexGet;
        1: seen = mStart;
        default: seen = overrun;
      endcase
    end
    if (seen && which == 0) last_get_cyc = cyc;
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic respond(input logic [15:0] rd, input bit err, input int lat);
    mBusy = 1'b1;
    repeat (lat) @(negedge clk);
    mDone  = 1'b1;
    mRdBuf = {16'h0, rd[7:0], rd[15:8]};
    if (err) begin
      if ($urandom_range(0, 1) == 1) mErrNack = 1'b1;
      else                           mErrLine = 1'b1;
    end
    @(negedge clk);
    mDone = 1'b0; mErrNack = 1'b0; mErrLine = 1'b0; mBusy = 1'b0;
  endtask

  task automatic clear_oc();
    ocClr = 1'b1;
    @(negedge clk);
    ocClr = 1'b0;
    oc_m = 1'b0;
    hist.delete();
    chk("oc_clr", 32'(ocIrq), 32'd0);
  endtask

  // Called one cycle after the good mDone; checks the publish 2 cycles after.
  task automatic finish_eval(input logic [15:0] rd, input bit clr_in_eval);
    bit all_over;
    chk("oc_pre", 32'(ocIrq), 32'(oc_m));
    if (clr_in_eval) ocClr = 1'b1;
    @(negedge clk);
    ocClr = 1'b0;
    hist.push_back(rd >= limit);
    all_over = (hist.size() >= CN);
    for (int k = 0; k < CN && all_over; k++)
      if (!hist[hist.size() - 1 - k]) all_over = 1'b0;
    if (all_over)         oc_m = 1'b1;
    else if (clr_in_eval) oc_m = 1'b0;
    if (clr_in_eval) hist.delete();
    chk("sv", 32'(sampleValid), 32'd1);
    chk("sample", 32'(sample), 32'(rd));
    chk("ocirq", 32'(ocIrq), 32'(oc_m));
    @(negedge clk);
    chk("sv_pulse", 32'(sampleValid), 32'd0);
  endtask

  task automatic run_poll(input logic [15:0] rd, input int nerr, input bit clr_in_eval);
    wait_sig(0, 2 * POLL_CYC + 10, "get");
    for (int a = 0; a <= nerr; a++) begin
      wait_sig(1, 10, "start");
      respond(rd, a < nerr, $urandom_range(1, 6));
    end
    finish_eval(rd, clr_in_eval);
  endtask

  initial begin
    int g0, s0, v0, o0, first_get;
    logic [15:0] rd;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_flags", {27'd0, sampleValid, ocIrq, fault, overrun, mStart}, 32'd0);
    chk("rst_get", 32'(mMutexGet), 32'd0);
    chk("rst_wrbuf", mWrBuf, 32'h0000_0001);
    chk("rst_lens", {26'd0, mWrLen, mRdLen}, {26'd0, 3'd1, 3'd2});
    chk("rst_addr", 32'(mAddr), 32'h40);
    rstn = 1'b1; enable = 1'b1;

    // Nominal poll
    s0 = n_start;
    wait_sig(0, 2 * POLL_CYC, "get_first");
    first_get = last_get_cyc;
    wait_sig(1, 10, "start_first");
    chk("start_lat", 32'(cyc - first_get), 32'd2);
    chk("wrbuf_ptr", 32'(mWrBuf[7:0]), 32'h01);
    chk("desc", {19'd0, mWrLen, mRdLen, mAddr}, {19'd0, 3'd1, 3'd2, 7'h40});
    respond(16'h1234, 1'b0, 3);
    finish_eval(16'h1234, 1'b0);
    chk("one_start", 32'(n_start - s0), 32'd1);
    run_poll(16'h0042, 0, 1'b0);
    chk("period", 32'(last_get_cyc - first_get), 32'(POLL_CYC));

    // Over-current: only the 4th sample completes a run of CONSEC_N
    limit = 16'h1000;
    run_poll(16'h1200, 0, 1'b0);
    run_poll(16'h0800, 0, 1'b0);
    run_poll(16'h1200, 0, 1'b0);
    run_poll(16'h1000, 0, 1'b0);
    clear_oc();
    run_poll(16'h1200, 0, 1'b0);
    run_poll(16'h1300, 0, 1'b1);   // ocClr lands on the set cycle
    run_poll(16'h0100, 0, 1'b0);   // sticky through an under-limit sample
    clear_oc();

    // Randomized readings near a random limit, random retries and clears
    for (int p = 0; p < 12; p++) begin
      if (p % 4 == 0) limit = 16'($urandom_range(16'h0100, 16'hF000));
      if ($urandom_range(0, 3) != 0) rd = 16'(int'(limit) + $urandom_range(0, 3));
      else                           rd = 16'(int'(limit) - 1 - $urandom_range(0, 3));
      run_poll(rd, $urandom_range(0, 2), 1'b0);
      if ($urandom_range(0, 4) == 0) clear_oc();
    end

    // NACK retry: 3 errors then success on one mutex grant
    g0 = n_get; s0 = n_start;
    run_poll(16'h2345, 3, 1'b0);
    chk("retry_starts", 32'(n_start - s0), 32'd4);
    chk("retry_gets", 32'(n_get - g0), 32'd1);
    chk("retry_fault", 32'(fault), 32'd0);

    // Retries exhausted
    wait_sig(0, 2 * POLL_CYC + 10, "get_ex");
    for (int a = 0; a <= RM; a++) begin
      wait_sig(1, 10, "start_ex");
      respond(16'h5555, 1'b1, 2);
    end
    @(negedge clk);
    chk("fault_ex", 32'(fault), 32'd1);
    g0 = n_get; s0 = n_start;
    repeat (2500) @(negedge clk);
    chk("fault_nostart", 32'(n_start - s0), 32'd0);
    chk("fault_noget", 32'(n_get - g0), 32'd0);
    faultClr = 1'b1;
    @(negedge clk);
    faultClr = 1'b0;
    chk("fault_clr", 32'(fault), 32'd0);
    run_poll(16'h0777, 0, 1'b0);

    // Mutex timeout
    mMutexSta = 1'b0;
    s0 = n_start;
    wait_sig(0, 2 * POLL_CYC + 10, "get_tmo");
    repeat (TMO) @(negedge clk);
    chk("tmo_early", 32'(fault), 32'd0);
    @(negedge clk);
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_nostart", 32'(n_start - s0), 32'd0);
    mMutexSta = 1'b1;
    faultClr = 1'b1;
    @(negedge clk);
    faultClr = 1'b0;

    // Overrun: transaction outlives a tick
    o0 = n_ovr;
    wait_sig(0, 2 * POLL_CYC + 10, "get_ovr");
    first_get = last_get_cyc;
    wait_sig(1, 10, "start_ovr");
    mBusy = 1'b1;
    wait_sig(2, POLL_CYC + 20, "ovr_seen");
    @(negedge clk);
    chk("ovr_pulse", 32'(overrun), 32'd0);
    respond(16'h0ABC, 1'b0, 2);
    finish_eval(16'h0ABC, 1'b0);
    chk("ovr_count", 32'(n_ovr - o0), 32'd1);
    run_poll(16'h0ABD, 0, 1'b0);
    chk("ovr_dropped", 32'(last_get_cyc - first_get), 32'(2 * POLL_CYC));

    // Reset in WAIT_DONE, then a stray mDone
    wait_sig(0, 2 * POLL_CYC + 10, "get_rst");
    wait_sig(1, 10, "start_rst");
    mBusy = 1'b1;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_sample", 32'(sample), 32'd0);
    chk("arst_flags", {26'd0, sampleValid, ocIrq, fault, overrun, mStart, mMutexGet}, 32'd0);
    chk("arst_const", mWrBuf, 32'h0000_0001);
    oc_m = 1'b0;
    hist.delete();
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    v0 = n_sv;
    respond(16'hBEEF, 1'b0, 1);
    repeat (10) @(negedge clk);
    chk("stray_sv", 32'(n_sv - v0), 32'd0);
    chk("stray_sample", 32'(sample), 32'd0);

    // Disabled: no requests
    enable = 1'b0;
    g0 = n_get;
    repeat (5000) @(negedge clk);
    chk("dis_noget", 32'(n_get - g0), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_curr_poller.md
Name: i2c_curr_poller

Overview:
Autonomous upstream sequencer for i2cMaster that periodically reads a 16-bit current register from an I2C current-sense device. It acquires the bus mutex, issues a pointer-write plus 2-byte-read transaction, and publishes the sample. It compares the sample against a programmable limit and raises a sticky over-current interrupt. It handles NACK/line errors with bounded retry and a fault flag.

Parameters:
SYS_CLK_FREQ, 10_000_000, system clock Hz
POLL_PERIOD_US, 1000, sample period in us; POLL_CYC = SYS_CLK_FREQ/1_000_000*POLL_PERIOD_US
DEV_ADDR, 7'h40, 7-bit device address driven on mAddr
REG_PTR, 8'h01, register pointer byte written before the read
CONSEC_N, 2, consecutive over-limit samples required to raise ocIrq (1..15)
RETRY_MAX, 3, retries per poll after an error before declaring fault
MUTEX_TMO_CYC, 4096, max cycles to wait for mutex ownership

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
enable  in  1  polling enable (level)
limit  in  16  unsigned over-current threshold
ocClr  in  1  one-cycle pulse, clears ocIrq and the consecutive counter
faultClr  in  1  one-cycle pulse, clears fault and resumes polling
mWrBuf  out  32  to i2cMaster wrBuf; {24'h0, REG_PTR}
mWrLen  out  3  constant 1
mRdLen  out  3  constant 2
mAddr  out  7  constant DEV_ADDR
mStart  out  1  one-cycle start pulse
mBusy  in  1  i2cMaster busy
mDone  in  1  one-cycle transaction-complete pulse
mErrLine  in  1  line error (valid with mDone)
mErrNack  in  1  NACK error (valid with mDone)
mRdBuf  in  32  read data; first byte received in [7:0], second in [15:8]
mMutexSta  in  1  1 = mutex owned by this master
mMutexGet  out  1  one-cycle mutex request pulse
sample  out  16  last good reading, {mRdBuf[7:0], mRdBuf[15:8]} (device MSB first)
sampleValid  out  1  one-cycle pulse when sample updates
ocIrq  out  1  sticky over-current interrupt
fault  out  1  sticky: retries exhausted or mutex timeout
overrun  out  1  one-cycle pulse when a tick arrives while a poll is still active

Behaviour:
- Reset (async, rstn=0): every output 0 except mWrBuf/mWrLen/mRdLen/mAddr, which hold their constants. State IDLE, tick counter = POLL_CYC-1, consecutive counter 0, retry counter 0.
- Tick counter: free-runs while enable=1 and counts down to 0. At 0 it reloads POLL_CYC-1 and generates tick. With enable=0 it is held at POLL_CYC-1 and the FSM returns to IDLE when the current transaction finishes, or immediately if none is in flight.
- States:
  - IDLE: on tick with fault=0 -> REQ.
  - REQ: pulse mMutexGet for 1 cycle -> WAIT_MTX.
  - WAIT_MTX: mMutexSta=1 and mBusy=0 -> START. After MUTEX_TMO_CYC cycles, set fault -> FAULT.
  - START: pulse mStart for 1 cycle -> WAIT_DONE.
  - WAIT_DONE: on mDone, go to EVAL if no error; otherwise go to ERR.
  - EVAL (1 cycle): register sample, pulse sampleValid, update the consecutive counter -> IDLE.
  - ERR: if retry<RETRY_MAX, increment retry -> START, without re-requesting the mutex. Else set fault -> FAULT.
  - FAULT: stays there; faultClr -> IDLE with the retry counter cleared.
- Retry counter clears on a successful EVAL.
- Compare rule: sample >= limit, unsigned. If true, increment the consecutive counter, saturating at CONSEC_N. If false, clear it. ocIrq is set in the cycle after the counter reaches CONSEC_N, which is 2 cycles after mDone.
- Simultaneous ocClr and set condition: set wins. ocIrq stays 1 and the counter is cleared to 0.
- A tick in any state other than IDLE pulses overrun and is dropped. It is not queued.
- mDone arriving outside WAIT_DONE is ignored.
- limit is sampled only in EVAL; changes mid-transaction have no effect.
- Latency: tick -> mMutexGet next cycle; mutex granted -> mStart one cycle after WAIT_MTX exit.
- Reset mid-transaction: all outputs return to reset values immediately. The i2cMaster is not aborted; a subsequent stray mDone is ignored.

Test Plan:
- Nominal poll (POLL_PERIOD_US=100, POLL_CYC=1000):
  - Stimulus: enable=1, grant mutex, return mRdBuf=32'h0000_3412.
  - Required: mStart pulses once with mWrBuf[7:0]=8'h01, mWrLen=1, mRdLen=2, mAddr=7'h40; sample=16'h1234 with a sampleValid pulse; next mMutexGet 1000 cycles after the first.
- Over-current with CONSEC_N=2, limit=16'h1000:
  - Stimulus: readings 16'h1200, 16'h0800, 16'h1200, 16'h1000.
  - Required: ocIrq rises only after the 4th sample, 2 cycles after its mDone. A later ocClr drops it, and ocClr coincident with the set cycle leaves it at 1.
- NACK retry, RETRY_MAX=3:
  - Stimulus: mErrNack with mDone 3 times, then success.
  - Required: 4 mStart pulses, 1 mMutexGet, fault stays 0, sample updates.
  - Stimulus: 4 consecutive errors.
  - Required: fault=1 and no further mStart on later ticks until faultClr.
- Mutex timeout:
  - Stimulus: hold mMutexSta=0.
  - Required: fault=1 exactly MUTEX_TMO_CYC cycles after entering WAIT_MTX, and mStart never asserted.
- Overrun:
  - Stimulus: hold mDone off for longer than 1000 cycles.
  - Required: a 1-cycle overrun pulse at the tick, with the poll completing normally afterwards.
- Reset/enable:
  - Stimulus: rstn low in WAIT_DONE.
  - Required: all outputs 0 asynchronously; a stray mDone after release produces no sampleValid.
  - Stimulus: enable=0.
  - Required: no mMutexGet for 5000 cycles.
